// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the decode-to-execute boundary: widths, the E-stage
// control bundle and its bubble encoding.
package pipeline_pkg;

  localparam int N    = 24;
  localparam int RA   = 4;
  localparam int ALUW = 3;

  typedef struct packed {
    logic            RegWrite;
    logic            MemWrite;
    logic            MemtoReg;
    logic            Branch;
    logic            ALUSrc;
    logic [ALUW-1:0] ALUControl;
  } ctrl_e_t;

  localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg_sfc.sv
// Generic W-bit pipeline register with async active-low reset, stall (hold)
// and flush (load zero); flush takes priority over stall.
module pipe_reg_sfc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (flush)       data_d = '0;
    else if (!stall) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall, flush and per-entry valid bit.
// Optional stall/flush performance counters when ID_EX_PERF_CNT_EN is defined.
module id_ex_register #(
  parameter int N    = pipeline_pkg::N,
  parameter int RA   = pipeline_pkg::RA,
  parameter int ALUW = pipeline_pkg::ALUW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic [N-1:0]    PCD,
  input  logic [N-1:0]    RD1D,
  input  logic [N-1:0]    RD2D,
  input  logic [N-1:0]    ExtImmD,
  input  logic [RA-1:0]   RdD,
  input  logic [RA-1:0]   Rs1D,
  input  logic [RA-1:0]   Rs2D,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            MemtoRegD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [ALUW-1:0] ALUControlD,
  output logic            ValidE,
  output logic [N-1:0]    PCE,
  output logic [N-1:0]    RD1E,
  output logic [N-1:0]    RD2E,
  output logic [N-1:0]    ExtImmE,
  output logic [RA-1:0]   RdE,
  output logic [RA-1:0]   Rs1E,
  output logic [RA-1:0]   Rs2E,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            MemtoRegE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [ALUW-1:0] ALUControlE,
  output logic            BubbleE
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]     StallCnt,
  output logic [31:0]     FlushCnt
`endif
);

  import pipeline_pkg::*;

  logic [4*N-1:0]  data_q;
  logic [3*RA-1:0] regs_q;
  ctrl_e_t         ctrl_in, ctrl_q;
  logic            valid_d, valid_q;

  // An invalid decode slot must never carry side effects into execute.
  always_comb begin
    ctrl_in = '{RegWrite:   RegWriteD,
                MemWrite:   MemWriteD,
                MemtoReg:   MemtoRegD,
                Branch:     BranchD,
                ALUSrc:     ALUSrcD,
                ALUControl: ALUControlD};
    if (!ValidD) begin
      ctrl_in.RegWrite = CTRL_BUBBLE.RegWrite;
      ctrl_in.MemWrite = CTRL_BUBBLE.MemWrite;
      ctrl_in.Branch   = CTRL_BUBBLE.Branch;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (FlushE)      valid_d = 1'b0;
    else if (!StallE) valid_d = ValidD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  pipe_reg_sfc #(.W(4*N)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (StallE),
    .flush (FlushE),
    .d     ({PCD, RD1D, RD2D, ExtImmD}),
    .q     (data_q)
  );

  pipe_reg_sfc #(.W(3*RA)) u_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (StallE),
    .flush (FlushE),
    .d     ({RdD, Rs1D, Rs2D}),
    .q     (regs_q)
  );

  pipe_reg_sfc #(.W($bits(ctrl_e_t))) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (StallE),
    .flush (FlushE),
    .d     (ctrl_in),
    .q     (ctrl_q)
  );

  assign {PCE, RD1E, RD2E, ExtImmE} = data_q;
  assign {RdE, Rs1E, Rs2E}          = regs_q;
  assign RegWriteE   = ctrl_q.RegWrite;
  assign MemWriteE   = ctrl_q.MemWrite;
  assign MemtoRegE   = ctrl_q.MemtoReg;
  assign BranchE     = ctrl_q.Branch;
  assign ALUSrcE     = ctrl_q.ALUSrc;
  assign ALUControlE = ctrl_q.ALUControl;
  assign ValidE      = valid_q;
  assign BubbleE     = ~valid_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (FlushE)      flush_cnt_d = flush_cnt_q + 32'd1;
    else if (StallE) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule
